// File: rtl/adder_pkg.sv
// Shared constants and helpers for the pipelined add/subtract unit.
package adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int seg_w(input int width, input int segs);
        return width / segs;
    endfunction

endpackage

// File: rtl/adder_seg.sv
// One carry-chain slice: W-bit add with carry-in, sum and carry registered on enable.
module adder_seg
    import adder_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum_q,
    output logic         cout_q
);

    logic [W-1:0] sum_d;
    logic         cout_d;

    always_comb begin
        {cout_d, sum_d} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (en) begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

endmodule

// File: rtl/adder_pipe.sv
// Pipelined add/subtract with valid/ready handshake; the carry chain is cut into SEGS
// registered slices, and a stall at the output freezes every stage together.
module adder_pipe
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SEGS  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             c_out,
    output logic             ovf_out
);

    localparam int W = seg_w(WIDTH, SEGS);

    if (SEGS < 1 || (WIDTH % SEGS) != 0) begin : g_bad_cfg
        $error("adder_pipe: WIDTH must be a multiple of SEGS and SEGS >= 1");
    end

    logic             adv;
    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    // Per-stage state: valid bit, operand delay lines, and finished lower sum slices.
    logic             v_q  [SEGS];
    logic             v_d  [SEGS];
    logic [WIDTH-1:0] a_q  [SEGS];
    logic [WIDTH-1:0] a_d  [SEGS];
    logic [WIDTH-1:0] b_q  [SEGS];
    logic [WIDTH-1:0] b_d  [SEGS];
    logic [WIDTH-1:0] sd_q [SEGS];
    logic [WIDTH-1:0] sd_d [SEGS];
    logic             cin_d[SEGS];
    logic [W-1:0]     seg_sum [SEGS];
    logic             seg_c   [SEGS];
    logic [WIDTH-1:0] full_sum[SEGS];

    assign is_sub    = (op_sub == OP_SUB);
    assign b_eff     = b_in ^ {WIDTH{is_sub}};
    assign cin_eff   = c_in ^ is_sub;
    assign out_valid = v_q[SEGS-1];
    assign adv       = !(out_valid && !out_ready);
    assign in_ready  = adv;

    always_comb begin
        for (int k = 0; k < SEGS; k++) begin
            full_sum[k]              = sd_q[k];
            full_sum[k][k*W +: W]    = seg_sum[k];
        end
    end

    always_comb begin
        v_d[0]   = in_valid;
        a_d[0]   = a_in;
        b_d[0]   = b_eff;
        sd_d[0]  = '0;
        cin_d[0] = cin_eff;
        for (int k = 1; k < SEGS; k++) begin
            v_d[k]   = v_q[k-1];
            a_d[k]   = a_q[k-1];
            b_d[k]   = b_q[k-1];
            sd_d[k]  = full_sum[k-1];
            cin_d[k] = seg_c[k-1];
        end
    end

    // Data registers load only with valid beats so outputs keep their last value across bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SEGS; k++) begin
                v_q[k]  <= 1'b0;
                a_q[k]  <= '0;
                b_q[k]  <= '0;
                sd_q[k] <= '0;
            end
        end else if (adv) begin
            for (int k = 0; k < SEGS; k++) begin
                v_q[k] <= v_d[k];
                if (v_d[k]) begin
                    a_q[k]  <= a_d[k];
                    b_q[k]  <= b_d[k];
                    sd_q[k] <= sd_d[k];
                end
            end
        end
    end

    for (genvar gi = 0; gi < SEGS; gi++) begin : g_seg
        adder_seg #(.W(W)) u_seg (
            .clk    (clk),
            .rst    (rst),
            .en     (adv && v_d[gi]),
            .a      (a_d[gi][gi*W +: W]),
            .b      (b_d[gi][gi*W +: W]),
            .cin    (cin_d[gi]),
            .sum_q  (seg_sum[gi]),
            .cout_q (seg_c[gi])
        );
    end

    assign sum_out = full_sum[SEGS-1];
    assign c_out   = seg_c[SEGS-1];
    assign ovf_out = (a_q[SEGS-1][WIDTH-1] == b_q[SEGS-1][WIDTH-1]) &&
                     (sum_out[WIDTH-1] != a_q[SEGS-1][WIDTH-1]);

endmodule
